// File: rtl/array_ctrl.sv
// array_ctrl: tile sequencer for a weight-stationary bit-serial systolic array; all outputs registered.
// Define ARRAY_CTRL_WREUSE_EN to add i_reuse_w (skip weight clear/load and keep resident weights).
module array_ctrl #(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int IWIDTH = 8,
  parameter int KWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [KWIDTH-1:0] i_k_len,
`ifdef ARRAY_CTRL_WREUSE_EN
  input  logic              i_reuse_w,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wght_rd,
  output logic              o_ifm_rd,
  output logic [HEIGHT-1:0] o_en_i,
  output logic [HEIGHT-1:0] o_clr_i,
  output logic [HEIGHT-1:0] o_mac_done,
  output logic [WIDTH-1:0]  o_en_w,
  output logic [WIDTH-1:0]  o_clr_w,
  output logic [WIDTH-1:0]  o_en_o,
  output logic [WIDTH-1:0]  o_clr_o,
  output logic [WIDTH-1:0]  o_ofm_vld
);

  localparam int CMAX = (2**KWIDTH - 1) * IWIDTH + HEIGHT - 1 + WIDTH;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WCLR, S_WLOAD, S_COMP, S_DRAIN, S_FIN} state_t;

  state_t            r_state, w_nxt_state;
  logic [CW-1:0]     r_cnt, w_nxt_cnt;
  logic [KWIDTH-1:0] r_klen, w_klen;
  logic [CW-1:0]     w_mac_len, w_comp_len, w_phase;
  logic              w_reuse, w_comp_act;
  logic [WIDTH-1:0]  w_en_o;

  logic              r_busy, r_done, r_wght_rd, r_ifm_rd;
  logic [HEIGHT-1:0] r_en_i, r_clr_i, r_mac_done;
  logic [WIDTH-1:0]  r_en_w, r_clr_w, r_en_o, r_clr_o, r_ofm_vld;

`ifdef ARRAY_CTRL_WREUSE_EN
  assign w_reuse = i_reuse_w;
`else
  assign w_reuse = 1'b0;
`endif

  // Outputs are registered from next-state values, so the tile length must be valid in the accept cycle too.
  assign w_klen     = (r_state == S_IDLE) ? i_k_len : r_klen;
  assign w_mac_len  = CW'(w_klen) * CW'(IWIDTH);
  assign w_comp_len = w_mac_len + CW'(HEIGHT - 1 + WIDTH);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = '0;
        if (i_start) begin
          if (w_klen == '0)  w_nxt_state = S_FIN;
          else if (w_reuse)  w_nxt_state = S_COMP;
          else               w_nxt_state = S_WCLR;
        end
      end
      S_WCLR: begin
        w_nxt_state = S_WLOAD;
        w_nxt_cnt   = '0;
      end
      S_WLOAD: begin
        if (r_cnt == CW'(HEIGHT - 1)) begin
          w_nxt_state = S_COMP;
          w_nxt_cnt   = '0;
        end
      end
      S_COMP: begin
        if (r_cnt == w_comp_len - CW'(1)) begin
          w_nxt_state = S_DRAIN;
          w_nxt_cnt   = '0;
        end
      end
      S_DRAIN: begin
        if (r_cnt == CW'(HEIGHT + WIDTH - 2)) begin
          w_nxt_state = S_FIN;
          w_nxt_cnt   = '0;
        end
      end
      S_FIN: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  assign w_comp_act = (w_nxt_state == S_COMP) && (w_nxt_cnt < w_mac_len);
  assign w_phase    = w_nxt_cnt % CW'(IWIDTH);

  always_comb begin
    w_en_o = '0;
    for (int w = 0; w < WIDTH; w++)
      w_en_o[w] = (w_nxt_state == S_DRAIN) && (w_nxt_cnt >= CW'(w)) && (w_nxt_cnt < CW'(w + HEIGHT));
  end

  // Rows 1..HEIGHT-1 are the row-0 pattern delayed through a shift chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_klen     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wght_rd  <= 1'b0;
      r_ifm_rd   <= 1'b0;
      r_en_i     <= '0;
      r_clr_i    <= '0;
      r_mac_done <= '0;
      r_en_w     <= '0;
      r_clr_w    <= '0;
      r_en_o     <= '0;
      r_clr_o    <= '0;
      r_ofm_vld  <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      if (r_state == S_IDLE && i_start) r_klen <= i_k_len;
      r_busy     <= (w_nxt_state != S_IDLE);
      r_done     <= (w_nxt_state == S_FIN);
      r_wght_rd  <= (w_nxt_state == S_WLOAD);
      r_en_w     <= {WIDTH{w_nxt_state == S_WLOAD}};
      r_clr_w    <= {WIDTH{w_nxt_state == S_WCLR}};
      r_clr_o    <= {WIDTH{(w_nxt_state == S_WCLR) ||
                           (r_state == S_IDLE && w_nxt_state == S_COMP)}};
      r_ifm_rd   <= w_comp_act && (w_phase == '0);
      r_en_i     <= {r_en_i[HEIGHT-2:0], w_comp_act};
      r_clr_i    <= {r_clr_i[HEIGHT-2:0], w_comp_act && (w_nxt_cnt == '0)};
      r_mac_done <= {r_mac_done[HEIGHT-2:0], w_comp_act && (w_phase == CW'(IWIDTH - 1))};
      r_en_o     <= w_en_o;
      r_ofm_vld  <= r_en_o;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_wght_rd  = r_wght_rd;
  assign o_ifm_rd   = r_ifm_rd;
  assign o_en_i     = r_en_i;
  assign o_clr_i    = r_clr_i;
  assign o_mac_done = r_mac_done;
  assign o_en_w     = r_en_w;
  assign o_clr_w    = r_clr_w;
  assign o_en_o     = r_en_o;
  assign o_clr_o    = r_clr_o;
  assign o_ofm_vld  = r_ofm_vld;

endmodule

// File: tb/tb_array_ctrl.sv
// Bench for array_ctrl: per-cycle expected output vectors queued per scenario and compared at negedge.
module tb_array_ctrl;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int IW = 8;
  localparam int KW = 8;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         wght_rd;
    logic         ifm_rd;
    logic [H-1:0] en_i;
    logic [H-1:0] clr_i;
    logic [H-1:0] mac_done;
    logic [W-1:0] en_w;
    logic [W-1:0] clr_w;
    logic [W-1:0] en_o;
    logic [W-1:0] clr_o;
    logic [W-1:0] ofm_vld;
  } out_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
`ifdef ARRAY_CTRL_WREUSE_EN
  logic          reuse_w = 1'b0;
`endif
  logic          busy, done, wght_rd, ifm_rd;
  logic [H-1:0]  en_i, clr_i, mac_done;
  logic [W-1:0]  en_w, clr_w, en_o, clr_o, ofm_vld;
  out_t          obs;

  int n_checks = 0;
  int n_errors = 0;
  out_t sb_q[$];

  always #5 clk = ~clk;

  array_ctrl #(.HEIGHT(H), .WIDTH(W), .IWIDTH(IW), .KWIDTH(KW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_k_len(k_len),
`ifdef ARRAY_CTRL_WREUSE_EN
    .i_reuse_w(reuse_w),
`endif
    .o_busy(busy), .o_done(done), .o_wght_rd(wght_rd), .o_ifm_rd(ifm_rd),
    .o_en_i(en_i), .o_clr_i(clr_i), .o_mac_done(mac_done),
    .o_en_w(en_w), .o_clr_w(clr_w), .o_en_o(en_o), .o_clr_o(clr_o), .o_ofm_vld(ofm_vld)
  );

  assign obs = '{busy, done, wght_rd, ifm_rd, en_i, clr_i, mac_done, en_w, clr_w, en_o, clr_o, ofm_vld};

  // Expected outputs c cycles after the accept cycle (c=0), straight from the tile timing description.
  function automatic out_t exp_at(int c, int k, bit reuse);
    out_t e;
    int cs, ds, fin, t, d;
    e = '0;
    if (c < 1) return e;
    if (k == 0) begin
      if (c == 1) begin e.busy = 1'b1; e.done = 1'b1; end
      return e;
    end
    cs  = reuse ? 1 : 6;
    ds  = cs + k * IW + (H - 1) + W;
    fin = ds + H + W - 1;
    e.busy = (c <= fin);
    e.done = (c == fin);
    if (!reuse) begin
      if (c == 1) begin e.clr_w = '1; e.clr_o = '1; end
      if (c >= 2 && c <= 1 + H) begin e.en_w = '1; e.wght_rd = 1'b1; end
    end else if (c == cs) begin
      e.clr_o = '1;
    end
    for (int h = 0; h < H; h++) begin
      t = c - cs - h;
      if (t >= 0 && t < k * IW) begin
        e.en_i[h] = 1'b1;
        if (t == 0) e.clr_i[h] = 1'b1;
        if (t % IW == IW - 1) e.mac_done[h] = 1'b1;
        if (h == 0 && t % IW == 0) e.ifm_rd = 1'b1;
      end
    end
    d = c - ds;
    for (int w = 0; w < W; w++) begin
      if (d >= w && d < w + H) e.en_o[w] = 1'b1;
      if (d - 1 >= w && d - 1 < w + H) e.ofm_vld[w] = 1'b1;
    end
    return e;
  endfunction

  function automatic int fin_of(int k, bit reuse);
    if (k == 0) return 1;
    return (reuse ? 1 : 6) + k * IW + (H - 1) + W + H + W - 1;
  endfunction

  task automatic test_reset();
    out_t e;
    #3;
    n_checks++;
    if (obs !== '0) begin
      n_errors++;
      $display("FAIL reset_during: got %h want %h", obs, out_t'('0));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) sb_q.push_back('0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL reset_idle c=%0d: got %h want %h", c, obs, e);
      end
    end
  endtask

  task automatic test_tile(int k, bit reuse, string name);
    out_t e;
    int n;
    n = fin_of(k, reuse) + 3;
    for (int c = 0; c < n; c++) sb_q.push_back(exp_at(c, k, reuse));
    k_len = KW'(k);
`ifdef ARRAY_CTRL_WREUSE_EN
    reuse_w = reuse;
`endif
    for (int c = 0; c < n; c++) begin
      start = (c == 0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL %s c=%0d: got %h want %h", name, c, obs, e);
      end
      @(negedge clk);
    end
    start = 1'b0;
`ifdef ARRAY_CTRL_WREUSE_EN
    reuse_w = 1'b0;
`endif
  endtask

  // start held through tile 1 into its post-FIN IDLE cycle, then stray pulses inside tile 2.
  task automatic test_back_to_back();
    out_t e;
    int f1, n, dones;
    f1 = fin_of(1, 1'b0);
    n  = 2 * (f1 + 1) + 3;
    dones = 0;
    for (int c = 0; c < n; c++) sb_q.push_back(out_t'(exp_at(c, 1, 1'b0) | exp_at(c - (f1 + 1), 1, 1'b0)));
    k_len = KW'(1);
    for (int c = 0; c < n; c++) begin
      start = (c <= f1 + 1) || (c == f1 + 8) || (c == f1 + 20);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL back_to_back c=%0d: got %h want %h", c, obs, e);
      end
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (dones != 2) begin
      n_errors++;
      $display("FAIL back_to_back_done_count: got %0d want 2", dones);
    end
  endtask

  task automatic test_reset_mid();
    out_t e;
    for (int c = 0; c < 15; c++) sb_q.push_back(exp_at(c, 2, 1'b0));
    k_len = KW'(2);
    for (int c = 0; c < 15; c++) begin
      start = (c == 0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL reset_mid_pre c=%0d: got %h want %h", c, obs, e);
      end
      if (c < 14) @(negedge clk);
    end
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_async: got %h want %h", obs, out_t'('0));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) sb_q.push_back('0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL reset_mid_quiet c=%0d: got %h want %h", c, obs, e);
      end
    end
    test_tile(2, 1'b0, "after_reset_tile");
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_tile(2, 1'b0, "tile_k2");
    test_tile(0, 1'b0, "tile_k0");
    test_tile(3, 1'b0, "tile_k3");
    test_back_to_back();
    test_reset_mid();
`ifdef ARRAY_CTRL_WREUSE_EN
    test_tile(1, 1'b1, "reuse_k1");
    test_tile(0, 1'b1, "reuse_k0");
    test_tile(2, 1'b0, "reload_after_reuse");
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
